// File: rtl/rgb_led_pwm_pkg.sv
// Shared constants for the RGB LED PWM block.
// Holds the register word offsets, the CTRL field layout, the period maximum helper and
// the byte-enable mask helper used by the bus decode.
package rgb_led_pwm_pkg;

   // Word index = device_addr_i[7:2]
   localparam int unsigned AddrWordLsb = 2;
   localparam int unsigned AddrWordMsb = 7;

   localparam logic [5:0] CtrlWord     = 6'h00;  // byte offset 0x00
   localparam logic [5:0] StatusWord   = 6'h01;  // byte offset 0x04
   localparam logic [5:0] DutyWordBase = 6'h10;  // byte offset 0x40

   // CTRL field positions
   localparam int unsigned CtrlEnableBit   = 0;
   localparam int unsigned CtrlPrescaleLsb = 16;
   localparam int unsigned PrescaleWidth   = 16;

   typedef struct packed {
      logic [PrescaleWidth-1:0] prescale;
      logic                     enable;
   } ctrl_t;

   // Last period counter value; a period is period_max + 1 ticks so that duty = all-ones
   // stays high for the whole period.
   function automatic int unsigned period_max(input int unsigned cnt_width);
      return (32'd1 << cnt_width) - 32'd2;
   endfunction

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: software-visible shadow duty, active duty reloaded at period boundaries
// (or continuously while disabled), and the registered compare output.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   enable_i       block enable (CTRL.enable)
//   load_i         period boundary strobe; active duty takes the shadow value
//   wr_en_i        shadow write strobe, wr_data_i already byte-merged
//   cnt_i          shared period counter
//   shadow_o       shadow duty for register readback
//   pwm_o          registered PWM output, active-high
module pwm_channel
   import rgb_led_pwm_pkg::*;
#(
   parameter int unsigned CntWidth = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic                load_i,
   input  logic                wr_en_i,
   input  logic [CntWidth-1:0] wr_data_i,
   input  logic [CntWidth-1:0] cnt_i,
   output logic [CntWidth-1:0] shadow_o,
   output logic                pwm_o
);

   logic [CntWidth-1:0] shadow_q, shadow_d;
   logic [CntWidth-1:0] active_q, active_d;
   logic                pwm_q, pwm_d;

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (wr_en_i) begin
         shadow_d = wr_data_i;
      end
      // Loads the pre-write shadow, so a write coinciding with a boundary waits a period
      if (!enable_i || load_i) begin
         active_d = shadow_q;
      end
      pwm_d = enable_i && (cnt_i < active_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= '0;
         active_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign shadow_o = shadow_q;
   assign pwm_o    = pwm_q;

endmodule

// File: rtl/rgb_led_pwm.sv
// RGB LED PWM controller with a simple request/response register bus.
// A prescaler divides the clock into ticks; a period counter runs 0..period_max on ticks and
// is shared by NumChannels pwm_channel instances.
// Ports:
//   clk_sys_i, rst_sys_ni     clock, asynchronous active-low reset
//   device_req_i/addr/we/be/wdata   register access request
//   device_rvalid_o/rdata_o   response one cycle after each request (writes read 0)
//   pwm_o                     PWM outputs, active-high
module rgb_led_pwm
   import rgb_led_pwm_pkg::*;
#(
   parameter int unsigned NumChannels = 12,
   parameter int unsigned CntWidth    = 8
) (
   input  logic                   clk_sys_i,
   input  logic                   rst_sys_ni,
   input  logic                   device_req_i,
   input  logic [31:0]            device_addr_i,
   input  logic                   device_we_i,
   input  logic [3:0]             device_be_i,
   input  logic [31:0]            device_wdata_i,
   output logic                   device_rvalid_o,
   output logic [31:0]            device_rdata_o,
   output logic [NumChannels-1:0] pwm_o
);

   localparam logic [CntWidth-1:0] PeriodMax = CntWidth'(period_max(CntWidth));

   logic [5:0]  word_idx;
   logic [31:0] be_mask;
   logic        wr_en;

   assign word_idx = device_addr_i[AddrWordMsb:AddrWordLsb];
   assign be_mask  = be_to_mask(device_be_i);
   assign wr_en    = device_req_i & device_we_i;

   // Only some address/data/mask bits are decoded; fold the rest into a sink
   logic unused_bits;
   logic [31:0] ctrl_merged;
   assign unused_bits = ^{device_addr_i, device_wdata_i, be_mask, ctrl_merged};

   // ---------------------------------------------------------------------------------------
   // CTRL register
   // ---------------------------------------------------------------------------------------
   ctrl_t       ctrl_q, ctrl_d;
   logic [31:0] ctrl_word;

   always_comb begin
      ctrl_word = '0;
      ctrl_word[CtrlEnableBit]                   = ctrl_q.enable;
      ctrl_word[CtrlPrescaleLsb +: PrescaleWidth] = ctrl_q.prescale;
      ctrl_merged = (ctrl_word & ~be_mask) | (device_wdata_i & be_mask);
      ctrl_d = ctrl_q;
      if (wr_en && (word_idx == CtrlWord)) begin
         ctrl_d.enable   = ctrl_merged[CtrlEnableBit];
         ctrl_d.prescale = ctrl_merged[CtrlPrescaleLsb +: PrescaleWidth];
      end
   end

   // ---------------------------------------------------------------------------------------
   // Prescaler and period counter
   // ---------------------------------------------------------------------------------------
   logic [PrescaleWidth-1:0] pre_cnt_q, pre_cnt_d;
   logic [CntWidth-1:0]      per_cnt_q, per_cnt_d;
   logic                     tick;
   logic                     load;

   always_comb begin
      pre_cnt_d = '0;
      per_cnt_d = '0;
      tick      = 1'b0;
      if (ctrl_q.enable) begin
         tick = (pre_cnt_q == ctrl_q.prescale);
         // ">=" lets a shrunk prescale wrap to 0 without producing a tick
         pre_cnt_d = (pre_cnt_q >= ctrl_q.prescale) ? '0 : pre_cnt_q + 1'b1;
         per_cnt_d = per_cnt_q;
         if (tick) begin
            per_cnt_d = (per_cnt_q == PeriodMax) ? '0 : per_cnt_q + 1'b1;
         end
      end
   end

   assign load = tick && (per_cnt_q == PeriodMax);

   // ---------------------------------------------------------------------------------------
   // Channels
   // ---------------------------------------------------------------------------------------
   logic [CntWidth-1:0]    shadow     [NumChannels];
   logic [CntWidth-1:0]    duty_wdata [NumChannels];
   logic [NumChannels-1:0] duty_we;

   for (genvar i = 0; i < NumChannels; i++) begin : g_chan
      assign duty_we[i]    = wr_en && (word_idx == DutyWordBase + 6'(i));
      assign duty_wdata[i] = (shadow[i] & ~be_mask[CntWidth-1:0]) |
                             (device_wdata_i[CntWidth-1:0] & be_mask[CntWidth-1:0]);

      pwm_channel #(
         .CntWidth (CntWidth)
      ) u_chan (
         .clk_i     (clk_sys_i),
         .rst_ni    (rst_sys_ni),
         .enable_i  (ctrl_q.enable),
         .load_i    (load),
         .wr_en_i   (duty_we[i]),
         .wr_data_i (duty_wdata[i]),
         .cnt_i     (per_cnt_q),
         .shadow_o  (shadow[i]),
         .pwm_o     (pwm_o[i])
      );
   end

   // ---------------------------------------------------------------------------------------
   // Read response
   // ---------------------------------------------------------------------------------------
   logic        rvalid_q;
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = '0;
      if (device_req_i && !device_we_i) begin
         if (word_idx == CtrlWord) begin
            rdata_d = ctrl_word;
         end else if (word_idx == StatusWord) begin
            rdata_d = 32'(per_cnt_q);
         end
         for (int i = 0; i < NumChannels; i++) begin
            if (word_idx == DutyWordBase + 6'(i)) begin
               rdata_d = 32'(shadow[i]);
            end
         end
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         ctrl_q    <= '0;
         pre_cnt_q <= '0;
         per_cnt_q <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         pre_cnt_q <= pre_cnt_d;
         per_cnt_q <= per_cnt_d;
         rvalid_q  <= device_req_i;
         rdata_q   <= rdata_d;
      end
   end

   assign device_rvalid_o = rvalid_q;
   assign device_rdata_o  = rdata_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Directed self-checking bench for rgb_led_pwm. Inputs are driven and outputs sampled on the
// falling clock edge; every task starts and ends on a falling edge.
module tb_rgb_led_pwm;

   localparam int unsigned NumCh = 12;
   localparam int unsigned CntW  = 8;
   localparam int          WaitMax = 5000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req;
   logic [31:0]      addr;
   logic             we;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic             rvalid;
   logic [31:0]      rdata;
   logic [NumCh-1:0] pwm;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rgb_led_pwm #(
      .NumChannels (NumCh),
      .CntWidth    (CntW)
   ) dut (
      .clk_sys_i       (clk),
      .rst_sys_ni      (rst_n),
      .device_req_i    (req),
      .device_addr_i   (addr),
      .device_we_i     (we),
      .device_be_i     (be),
      .device_wdata_i  (wdata),
      .device_rvalid_o (rvalid),
      .device_rdata_o  (rdata),
      .pwm_o           (pwm)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                            input string tag);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
      @(negedge clk);
      req = 1'b0; we = 1'b0; be = 4'h0; wdata = '0;
      check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
      check({tag, ".rdata"}, rdata, 32'd0);
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
      req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
      @(negedge clk);
      req = 1'b0; be = 4'h0;
      check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
      check({tag, ".rdata"}, rdata, exp);
   endtask

   // Returns the number of falling edges until pwm[ch] first shows lvl (WaitMax on timeout)
   task automatic wait_level(input int ch, input logic lvl, output int n);
      n = 0;
      while (n < WaitMax) begin
         @(negedge clk);
         n++;
         if (pwm[ch] === lvl) break;
      end
   endtask

   initial begin
      int n;
      int ones1;
      int ones2;
      int stray;
      logic [31:0] status_exp [8];

      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_pwm", 32'(pwm), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset values
      bus_read(32'h00, 32'd0, "rd_ctrl_rst");
      bus_read(32'h04, 32'd0, "rd_status_rst");
      bus_read(32'h40, 32'd0, "rd_duty0_rst");
      check("pwm_after_rst", 32'(pwm), 32'd0);

      // Duty programming, byte enables, ignored/unmapped offsets
      bus_write(32'h40, 32'd64, 4'hF, "wr_duty0");
      bus_write(32'h44, 32'd0, 4'hF, "wr_duty1");
      bus_write(32'h48, 32'd255, 4'hF, "wr_duty2");
      bus_write(32'h48, 32'h12, 4'h0, "wr_duty2_nobe");
      bus_read(32'h48, 32'd255, "rd_duty2");
      bus_write(32'h04, 32'hAB, 4'hF, "wr_status");
      bus_read(32'h04, 32'd0, "rd_status_ro");
      bus_write(32'h3C, 32'hFFFF_FFFF, 4'hF, "wr_unmapped");
      bus_read(32'h3C, 32'd0, "rd_unmapped");
      bus_read(32'h40, 32'd64, "rd_duty0");
      check("pwm_disabled", 32'(pwm), 32'd0);

      // Enable with prescale 0: first update one cycle after enable lands
      bus_write(32'h00, 32'h0000_0001, 4'hF, "wr_ctrl_en");
      check("pwm_at_enable", 32'(pwm[0]), 32'd0);
      wait_level(0, 1'b1, n);
      check("first_rise", 32'(n), 32'd1);
      wait_level(0, 1'b0, n);
      check("hi0_p1", 32'(n), 32'd64);
      wait_level(0, 1'b1, n);
      check("lo0_p1", 32'(n), 32'd191);
      wait_level(0, 1'b0, n);
      check("hi0_p2", 32'(n), 32'd64);
      wait_level(0, 1'b1, n);
      check("lo0_p2", 32'(n), 32'd191);

      // Duty 0 and 255 over three periods
      ones1 = 0;
      ones2 = 0;
      repeat (765) begin
         @(negedge clk);
         if (pwm[1] === 1'b1) ones1++;
         if (pwm[2] === 1'b1) ones2++;
      end
      check("duty0_ch1_ones", 32'(ones1), 32'd0);
      check("duty255_ch2_ones", 32'(ones2), 32'd765);

      // Counter now 1; advance to 100 then change DUTY0 to 200 mid-period
      repeat (99) @(negedge clk);
      bus_write(32'h40, 32'd200, 4'hF, "wr_duty0_mid");
      wait_level(0, 1'b1, n);
      check("no_mid_period_effect", 32'(n), 32'd155);
      wait_level(0, 1'b0, n);
      check("hi0_new", 32'(n), 32'd200);
      wait_level(0, 1'b1, n);
      check("lo0_new", 32'(n), 32'd55);

      // Prescale 3
      bus_write(32'h00, 32'd0, 4'hF, "wr_ctrl_dis");
      bus_write(32'h40, 32'd64, 4'hF, "wr_duty0_64");
      check("pwm_off_disabled", 32'(pwm), 32'd0);
      bus_write(32'h00, 32'h0003_0001, 4'hF, "wr_ctrl_ps3");
      wait_level(0, 1'b1, n);
      check("ps3_first_rise", 32'(n), 32'd1);
      wait_level(0, 1'b0, n);
      check("ps3_hi", 32'(n), 32'd256);
      wait_level(0, 1'b1, n);
      check("ps3_lo", 32'(n), 32'd764);
      status_exp = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
      for (int k = 0; k < 8; k++) begin
         bus_read(32'h04, status_exp[k], $sformatf("rd_status_ps3_%0d", k));
      end
      bus_write(32'h00, 32'h00FF_0001, 4'b0001, "wr_ctrl_be0");
      bus_read(32'h00, 32'h0003_0001, "rd_ctrl_be0");

      // Back to prescale 0, resync to a rising edge, then reset with counter at 150
      bus_write(32'h00, 32'h0000_0001, 4'hF, "wr_ctrl_ps0");
      wait_level(0, 1'b0, n);
      wait_level(0, 1'b1, n);
      check("ps0_resync_lo", 32'(n), 32'd191);
      repeat (149) @(negedge clk);
      check("pre_rst_ch2", 32'(pwm[2]), 32'd1);
      req = 1'b1; we = 1'b0; addr = 32'h40; be = 4'hF;
      @(posedge clk);
      #1;
      req = 1'b0;
      check("pre_rst_rvalid", 32'(rvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async_pwm", 32'(pwm), 32'd0);
      check("rst_async_rvalid", 32'(rvalid), 32'd0);
      check("rst_async_rdata", rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus_read(32'h00, 32'd0, "rd_ctrl_post");
      bus_read(32'h04, 32'd0, "rd_status_post");
      bus_read(32'h40, 32'd0, "rd_duty0_post");
      bus_read(32'h48, 32'd0, "rd_duty2_post");
      stray = 0;
      repeat (300) begin
         @(negedge clk);
         if (pwm !== '0) stray++;
      end
      check("pwm_low_post_rst", 32'(stray), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rgb_led_pwm.md
RGB_LED_PWM -- requirements
Module: rgb_led_pwm

Interface
REQ-001 The block SHALL have parameter NumChannels, default 12, meaning the number of PWM outputs (4 RGB LEDs x 3 colours).
REQ-002 The block SHALL have parameter CntWidth, default 8, meaning the duty and period counter width.
REQ-003 The block SHALL have port clk_sys_i  input  1  system clock; all logic is in this single clock domain.
REQ-004 The block SHALL have port rst_sys_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port device_req_i  input  1  bus access request.
REQ-006 The block SHALL have port device_addr_i  input  32  byte address; only bits [7:2] are decoded.
REQ-007 The block SHALL have port device_we_i  input  1  write enable.
REQ-008 The block SHALL have port device_be_i  input  4  byte enables.
REQ-009 The block SHALL have port device_wdata_i  input  32  write data.
REQ-010 The block SHALL have port device_rvalid_o  output  1  response valid.
REQ-011 The block SHALL have port device_rdata_o  output  32  read data.
REQ-012 The block SHALL have port pwm_o  output  NumChannels  PWM outputs to RGB_LED pins, active-high.

Function
REQ-013 Register map (word offsets): 0x00 CTRL = [0] enable, [31:16] prescale; 0x04 STATUS = [CntWidth-1:0] period counter, read-only; 0x40+4*i DUTY[i] = [CntWidth-1:0] shadow duty, for i < NumChannels.
REQ-014 Writes SHALL update only the bytes whose device_be_i bit is set; writes to STATUS or unmapped offsets SHALL be ignored.
REQ-015 device_rvalid_o SHALL assert exactly one cycle after every accepted device_req_i, for reads and writes alike.
REQ-016 device_rdata_o SHALL carry the addressed register in the device_rvalid_o cycle; unmapped offsets and write responses SHALL read 0.
REQ-017 Prescaler: counts 0..prescale; tick asserts in the cycle it equals prescale, then it wraps to 0; prescale=0 SHALL tick every cycle.
REQ-018 Period counter: advances on each tick over 0..2^CntWidth-2 (0..254), wrapping to 0 after 254; one period = 255 ticks.
REQ-019 Each channel SHALL hold an active duty register, loaded from its DUTY shadow on a tick where the period counter = 254 (period boundary); duty changes never take effect mid-period.
REQ-020 pwm_o[i] SHALL be a register set to (period counter < active duty[i]); duty 0 is constantly low, duty 255 is constantly high, and output latency is 1 cycle after the counter value.
REQ-021 With enable=0: prescaler and period counter SHALL be held at 0, pwm_o all 0, and active duty continuously copied from the shadow.
REQ-022 On an enable 0->1 transition, counting SHALL start from 0 with the active duties current at that moment; the first pwm_o update follows one cycle later.
REQ-023 A CTRL write that changes prescale while enabled SHALL take effect immediately; if the prescaler is already above the new value, it SHALL wrap to 0 on the next cycle without ticking.
REQ-024 A DUTY write in the same cycle as a period-boundary load SHALL be captured in the shadow only; the active duty loads the old shadow value.

Reset
REQ-025 Asserting rst_sys_ni low SHALL immediately clear CTRL, all DUTY shadows, all active duties, both counters, pwm_o, device_rvalid_o and device_rdata_o to 0, including mid-period or mid-access.
REQ-026 After reset release, pwm_o SHALL remain 0 until software sets CTRL.enable.

Structure
REQ-027 Register offsets, CTRL field positions and the period maximum constant SHALL live in shared package rgb_led_pwm_pkg.
REQ-028 A per-channel sub-module pwm_channel (shadow-to-active load plus compare/output register) SHALL be instantiated NumChannels times by a generate loop; the counters and bus decode stay in rgb_led_pwm.

Verification
REQ-029 Reset, then read 0x00, 0x04, 0x40 -> each rdata 0 with rvalid one cycle after req; pwm_o = 0.
REQ-030 DUTY0=64, prescale=0, enable=1 -> pwm_o[0] is high for 64 and low for 191 cycles, repeating with a 255-cycle period.
REQ-031 DUTY1=0 and DUTY2=255, enabled -> pwm_o[1] is constantly 0 and pwm_o[2] is constantly 1 across 3 periods.
REQ-032 Mid-period, with the counter at 100, write DUTY0 from 64 to 200 -> high time is still 64 in the current period and 200 from the next.
REQ-033 prescale=3 -> STATUS advances once every 4 cycles and the period is 1020 cycles; a write with be=4'b0001 to CTRL leaves prescale unchanged.
REQ-034 Assert rst_sys_ni low with the counter at 150 -> all outputs are 0 in the same cycle; after release, reads return 0 and pwm_o stays low.
